// File: rtl/rtc_secuenciador_bus.sv
// Bus-cycle sequencer for the multiplexed address/data RTC interface.
// Walks address, gap, data and gap phases timed by an external phase counter.
module rtc_secuenciador_bus #(
    parameter int unsigned T_DIR  = 10,
    parameter int unsigned T_DATO = 20,
    parameter int unsigned T_ESP  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       rw,
    input  logic [7:0] dir,
    input  logic [7:0] dato_in,
    input  logic [4:0] cuenta,
    input  logic [7:0] bus_in,
    output logic       EN_cuenta,
    output logic [5:0] tiempo,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       bus_oe,
    output logic [7:0] bus_out,
    output logic [7:0] dato_leido,
    output logic       ocupado,
    output logic       listo
);

    localparam logic [5:0] L_DIR      = 6'(T_DIR);
    localparam logic [5:0] L_DATO     = 6'(T_DATO);
    localparam logic [5:0] L_ESP      = 6'(T_ESP);
    localparam logic [4:0] L_DIR_STB  = 5'(T_DIR - 2);
    localparam logic [4:0] L_DATO_STB = 5'(T_DATO - 2);

    typedef enum logic [2:0] {
        REPOSO,
        DIRECCION,
        ESPERA1,
        DATO,
        ESPERA2
    } estado_t;

    estado_t    r_estado;
    logic       r_rw;
    logic [7:0] r_dir;
    logic [7:0] r_dato;

    logic       w_fin;
    logic       w_dir_stb;
    logic       w_dato_stb;

    // Strobes stay high on the first and last count of each phase.
    assign w_dir_stb  = (cuenta != 5'd0) && (cuenta <= L_DIR_STB);
    assign w_dato_stb = (cuenta != 5'd0) && (cuenta <= L_DATO_STB);
    assign w_fin      = EN_cuenta && ({1'b0, cuenta} == (tiempo - 6'd1));

    // Pin decode from the state register and the phase count.
    always_comb begin
        EN_cuenta = 1'b1;
        tiempo    = L_ESP;
        cs_n      = 1'b1;
        ad_n      = 1'b1;
        wr_n      = 1'b1;
        rd_n      = 1'b1;
        bus_oe    = 1'b0;
        bus_out   = 8'h00;
        ocupado   = 1'b1;
        case (r_estado)
            REPOSO: begin
                EN_cuenta = 1'b0;
                tiempo    = L_DIR;
                ocupado   = 1'b0;
            end
            DIRECCION: begin
                tiempo  = L_DIR;
                cs_n    = 1'b0;
                ad_n    = 1'b0;
                bus_oe  = 1'b1;
                bus_out = r_dir;
                wr_n    = !w_dir_stb;
            end
            DATO: begin
                tiempo = L_DATO;
                cs_n   = 1'b0;
                if (r_rw) begin
                    rd_n = !w_dato_stb;
                end else begin
                    bus_oe  = 1'b1;
                    bus_out = r_dato;
                    wr_n    = !w_dato_stb;
                end
            end
            default: ;
        endcase
    end

    // Phase sequencing, request latching, read capture and completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado   <= REPOSO;
            r_rw       <= 1'b0;
            r_dir      <= 8'h00;
            r_dato     <= 8'h00;
            dato_leido <= 8'h00;
            listo      <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_rw     <= rw;
                        r_dir    <= dir;
                        r_dato   <= dato_in;
                        r_estado <= DIRECCION;
                    end
                end
                DIRECCION: if (w_fin) r_estado <= ESPERA1;
                ESPERA1:   if (w_fin) r_estado <= DATO;
                DATO: begin
                    if (r_rw && (cuenta == L_DATO_STB)) dato_leido <= bus_in;
                    if (w_fin) r_estado <= ESPERA2;
                end
                ESPERA2: begin
                    if (w_fin) begin
                        r_estado <= REPOSO;
                        listo    <= 1'b1;
                    end
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

endmodule
